prog_counter: RTL and testbench

Parametrised successor to the team's fixed 4-bit free-running counter. Configurable width, runtime-selectable up/down/bounce/hold mode, programmable terminal value, parallel load, synchronous clear and a clock-enable prescaler. Emits a one-cycle terminal-count pulse and a sticky wrap flag. Used as the generic timebase/event counter across ASIC and FPGA comparison builds.

---
 rtl/prog_counter_if.sv | 29 ++
 rtl/prog_counter.sv | 122 ++++++++++++
 tb/tb_prog_counter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_counter_if.sv
// Control and status bundle for prog_counter; the master drives controls and the slave (counter) drives status.
// Status signals are registered inside the counter; there is no handshake, so every field is sampled each clock.
interface prog_counter_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic                  en;
  logic                  clr;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [1:0]            mode;
  logic [WIDTH-1:0]      max_val;
  logic [PRESCALE_W-1:0] presc;
  logic                  ovf_clr;
  logic [WIDTH-1:0]      count;
  logic                  dir;
  logic                  tc;
  logic                  wrap_sticky;

  modport master (
    output en, clr, load, load_val, mode, max_val, presc, ovf_clr,
    input  count, dir, tc, wrap_sticky
  );

  modport slave (
    input  en, clr, load, load_val, mode, max_val, presc, ovf_clr,
    output count, dir, tc, wrap_sticky
  );
endinterface

// File: rtl/prog_counter.sv
// Programmable up/down/bounce/hold counter with prescaler, terminal-count pulse and sticky wrap flag.
// All outputs registered: a step is visible one cycle after its prescaler tick; no backpressure, inputs sampled every clock.
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  prog_counter_if.slave  bus
);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PC_ONE  = PRESCALE_W'(1);

  logic [WIDTH-1:0]      count_q;
  logic                  dir_q;
  logic                  tc_q;
  logic                  wrap_q;
  logic [PRESCALE_W-1:0] pc_q;

  logic                  tick;
  logic [WIDTH-1:0]      nxt_count;
  logic                  nxt_dir;
  logic                  wrap_evt;

  assign tick = bus.en && (pc_q == bus.presc);

  // Next step value assuming a tick occurs; only committed on a tick.
  always_comb begin
    nxt_count = count_q;
    nxt_dir   = dir_q;
    wrap_evt  = 1'b0;
    case (bus.mode)
      MODE_UP: begin
        nxt_dir = 1'b1;
        if (count_q >= bus.max_val) begin
          nxt_count = '0;
          wrap_evt  = 1'b1;
        end else begin
          nxt_count = count_q + CNT_ONE;
        end
      end
      MODE_DOWN: begin
        nxt_dir = 1'b0;
        if (count_q == '0) begin
          nxt_count = bus.max_val;
          wrap_evt  = 1'b1;
        end else begin
          nxt_count = count_q - CNT_ONE;
        end
      end
      MODE_BOUNCE: begin
        if (dir_q) begin
          if (count_q >= bus.max_val) begin
            nxt_dir   = 1'b0;
            wrap_evt  = 1'b1;
            nxt_count = (bus.max_val == '0) ? '0 : bus.max_val - CNT_ONE;
          end else begin
            nxt_count = count_q + CNT_ONE;
          end
        end else begin
          if (count_q == '0) begin
            nxt_dir   = 1'b1;
            wrap_evt  = 1'b1;
            nxt_count = (bus.max_val == '0) ? '0 : CNT_ONE;
          end else begin
            nxt_count = count_q - CNT_ONE;
          end
        end
      end
      MODE_HOLD: begin
        nxt_count = count_q;
        nxt_dir   = dir_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
      pc_q    <= '0;
    end else begin
      tc_q <= 1'b0;
      if (bus.ovf_clr) begin
        wrap_q <= 1'b0;
      end
      if (bus.clr) begin
        count_q <= '0;
        dir_q   <= 1'b1;
        pc_q    <= '0;
      end else if (bus.load) begin
        count_q <= bus.load_val;
        pc_q    <= '0;
      end else if (bus.en) begin
        pc_q <= tick ? '0 : pc_q + PC_ONE;
        if (tick) begin
          count_q <= nxt_count;
          dir_q   <= nxt_dir;
          // Setting the sticky flag overrides a same-cycle ovf_clr.
          if (wrap_evt) begin
            tc_q   <= 1'b1;
            wrap_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.count       = count_q;
  assign bus.dir         = dir_q;
  assign bus.tc          = tc_q;
  assign bus.wrap_sticky = wrap_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter at WIDTH=4: hand-computed count/dir/tc/wrap sequences per mode.
module tb_prog_counter;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  prog_counter_if #(.WIDTH(4), .PRESCALE_W(4)) bus ();

  prog_counter #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int dn_c   [5] = '{2, 1, 0, 5, 4};
  int dn_tc  [5] = '{0, 0, 0, 1, 0};
  int bn_c   [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
  int bn_tc  [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
  int bn_dir [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
  int z_dir  [3] = '{0, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total        = 0;
    passed       = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.mode     = 2'b00;
    bus.max_val  = 4'd15;
    bus.presc    = '0;
    bus.ovf_clr  = 1'b0;

    #12;
    chk("rst_count", bus.count, 0);
    chk("rst_dir", bus.dir, 1);
    chk("rst_tc", bus.tc, 0);
    chk("rst_wrap", bus.wrap_sticky, 0);
    rst_n  = 1'b1;
    bus.en = 1'b1;

    // Up, full range: natural rollover 15 -> 0 with tc.
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("up15_count", bus.count, k % 16);
      chk("up15_tc", bus.tc, (k == 16) ? 1 : 0);
    end
    chk("up15_wrap", bus.wrap_sticky, 1);
    step();
    chk("up15_after_count", bus.count, 1);
    chk("up15_after_tc", bus.tc, 0);

    bus.clr     = 1'b1;
    bus.ovf_clr = 1'b1;
    step();
    chk("clr_count", bus.count, 0);
    chk("clr_dir", bus.dir, 1);
    chk("ovfclr_wrap", bus.wrap_sticky, 0);
    bus.clr     = 1'b0;
    bus.ovf_clr = 1'b0;

    // Prescale by 3, then freeze with en low partway through a period.
    bus.max_val = 4'd9;
    bus.presc   = 4'd2;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("presc_count", bus.count, k / 3);
    end
    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("freeze_count", bus.count, 2);
    end
    bus.en = 1'b1;
    step();
    chk("resume_phase_count", bus.count, 2);
    step();
    chk("resume_tick_count", bus.count, 3);

    bus.load_val = 4'd8;
    bus.load     = 1'b1;
    step();
    chk("load8_count", bus.count, 8);
    bus.load = 1'b0;
    step();
    step();
    step();
    chk("presc_9_count", bus.count, 9);
    chk("presc_9_tc", bus.tc, 0);
    step();
    step();
    step();
    chk("presc_wrap_count", bus.count, 0);
    chk("presc_wrap_tc", bus.tc, 1);
    chk("presc_wrap_sticky", bus.wrap_sticky, 1);
    step();
    chk("presc_tc_drop", bus.tc, 0);

    // Down from a loaded value, then from above max_val.
    bus.mode     = 2'b01;
    bus.max_val  = 4'd5;
    bus.presc    = '0;
    bus.load_val = 4'd3;
    bus.load     = 1'b1;
    step();
    chk("dn_load_count", bus.count, 3);
    chk("dn_load_dir", bus.dir, 1);
    bus.load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("dn_count", bus.count, dn_c[k]);
      chk("dn_tc", bus.tc, dn_tc[k]);
    end
    chk("dn_dir", bus.dir, 0);

    bus.load_val = 4'd12;
    bus.load     = 1'b1;
    step();
    chk("dn_load12", bus.count, 12);
    bus.load = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("dn12_count", bus.count, (k <= 12) ? 12 - k : 5);
      chk("dn12_tc", bus.tc, (k == 13) ? 1 : 0);
    end

    // Bounce between 0 and 3.
    bus.clr = 1'b1;
    step();
    chk("bn_clr_dir", bus.dir, 1);
    bus.clr     = 1'b0;
    bus.mode    = 2'b10;
    bus.max_val = 4'd3;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("bn_count", bus.count, bn_c[k]);
      chk("bn_tc", bus.tc, bn_tc[k]);
      chk("bn_dir", bus.dir, bn_dir[k]);
    end

    // Bounce with max_val 0: turnaround, and tc, on every tick.
    bus.max_val = 4'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bn0_count", bus.count, 0);
      chk("bn0_tc", bus.tc, 1);
      chk("bn0_dir", bus.dir, z_dir[k]);
    end

    // clr beats load; then hold mode does not move.
    bus.mode     = 2'b11;
    bus.max_val  = 4'd15;
    bus.clr      = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 4'd7;
    step();
    chk("clr_load_count", bus.count, 0);
    chk("clr_load_dir", bus.dir, 1);
    bus.clr  = 1'b0;
    bus.load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("hold_count", bus.count, 0);
      chk("hold_tc", bus.tc, 0);
    end

    // Sticky flag: set beats simultaneous ovf_clr.
    bus.mode    = 2'b00;
    bus.max_val = 4'd1;
    bus.ovf_clr = 1'b1;
    step();
    chk("stk_count1", bus.count, 1);
    chk("stk_clr_only", bus.wrap_sticky, 0);
    step();
    chk("stk_wrap_tc", bus.tc, 1);
    chk("stk_set_wins", bus.wrap_sticky, 1);
    step();
    chk("stk_clear_next", bus.wrap_sticky, 0);
    bus.ovf_clr = 1'b0;

    // Async reset mid-count.
    bus.max_val  = 4'd15;
    bus.load_val = 4'd15;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    chk("pre_rst_wrap", bus.wrap_sticky, 1);
    bus.load_val = 4'd6;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    chk("pre_rst_count", bus.count, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_tc", bus.tc, 0);
    chk("arst_wrap", bus.wrap_sticky, 0);
    chk("arst_dir", bus.dir, 1);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_count", bus.count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
